// File: rtl/first_nios1_system_cpu_oci_trace_capture_if.sv
// Trace-capture bus: trace input, drain control, dump handshake and status.
// master = trace source / dump sink, slave = capture buffer.
interface first_nios1_system_cpu_oci_trace_capture_if #(
    parameter int unsigned DATA_W = 30,
    parameter int unsigned AW     = 4
);
    logic              trc_valid;
    logic [DATA_W-1:0] trc_data;
    logic              test_ending;
    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic              dump_ready;
    logic [AW:0]       dct_count;
    logic              overflow;
    logic              test_has_ended;

    modport master (
        output trc_valid, trc_data, test_ending, dump_ready,
        input  dump_valid, dump_data, dct_count, overflow, test_has_ended
    );

    modport slave (
        input  trc_valid, trc_data, test_ending, dump_ready,
        output dump_valid, dump_data, dct_count, overflow, test_has_ended
    );
endinterface

// File: rtl/first_nios1_system_cpu_oci_trace_capture.sv
// OCI trace capture buffer: circular store of trace words, drained oldest-first
// over a valid/ready port once test_ending is seen, then flags test_has_ended.
module first_nios1_system_cpu_oci_trace_capture #(
    parameter int unsigned DATA_W    = 30,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AW        = $clog2(DEPTH),
    parameter int unsigned OVERWRITE = 0
) (
    input  logic clk,
    input  logic reset_n,
    first_nios1_system_cpu_oci_trace_capture_if.slave bus
);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [AW-1:0] ONE_P = AW'(1);

    typedef enum logic [1:0] {
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              dump_valid_q, dump_valid_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic              ended_q, ended_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Next-state, pointer/count update and dump-word prefetch
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        dump_valid_d = 1'b0;
        dump_data_d  = dump_data_q;
        ended_d      = ended_q;
        mem_we       = 1'b0;

        unique case (state_q)
            ST_CAPTURE: begin
                if (bus.trc_valid) begin
                    if (count_q != FULL) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_P;
                        count_d  = count_q + ONE_C;
                    end else begin
                        overflow_d = 1'b1;
                        if (OVERWRITE != 0) begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + ONE_P;
                            rd_ptr_d = rd_ptr_q + ONE_P;
                        end
                    end
                end
                if (bus.test_ending) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_q == '0) begin
                    state_d = ST_DONE;
                end else if (dump_valid_q && bus.dump_ready) begin
                    rd_ptr_d = rd_ptr_q + ONE_P;
                    count_d  = count_q - ONE_C;
                end
            end
            ST_DONE: begin
                ended_d = 1'b1;
            end
            default: begin
                state_d = ST_CAPTURE;
            end
        endcase

        if (state_d == ST_DONE) begin
            ended_d = 1'b1;
        end

        // Present the head word the same edge it becomes available; a word
        // written this edge at the read slot is forwarded from the input.
        dump_valid_d = (state_d == ST_DRAIN) && (count_d != '0);
        if (dump_valid_d) begin
            if (mem_we && (wr_ptr_q == rd_ptr_d)) begin
                dump_data_d = bus.trc_data;
            end else begin
                dump_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_CAPTURE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            ended_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
            ended_q      <= ended_d;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.trc_data;
        end
    end

    assign bus.dump_valid     = dump_valid_q;
    assign bus.dump_data      = dump_data_q;
    assign bus.dct_count      = count_q;
    assign bus.overflow       = overflow_q;
    assign bus.test_has_ended = ended_q;

endmodule

// File: tb/tb_first_nios1_system_cpu_oci_trace_capture.sv
// Bench: drop-mode (dut0) and ring-mode (dut1) buffers share one stimulus
// stream; a queue-based model and a directed vector table check both.
module tb_first_nios1_system_cpu_oci_trace_capture;
    localparam int unsigned DW    = 30;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    typedef logic [DW-1:0] word_t;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  tv, te, dr;
    word_t td;

    always #5 clk = ~clk;

    first_nios1_system_cpu_oci_trace_capture_if #(.DATA_W(DW), .AW(AW)) ifc0 ();
    first_nios1_system_cpu_oci_trace_capture_if #(.DATA_W(DW), .AW(AW)) ifc1 ();

    assign ifc0.trc_valid   = tv;
    assign ifc0.trc_data    = td;
    assign ifc0.test_ending = te;
    assign ifc0.dump_ready  = dr;
    assign ifc1.trc_valid   = tv;
    assign ifc1.trc_data    = td;
    assign ifc1.test_ending = te;
    assign ifc1.dump_ready  = dr;

    first_nios1_system_cpu_oci_trace_capture #(
        .DATA_W(DW), .DEPTH(DEPTH), .AW(AW), .OVERWRITE(0)
    ) dut0 (.clk(clk), .reset_n(rst_n), .bus(ifc0));

    first_nios1_system_cpu_oci_trace_capture #(
        .DATA_W(DW), .DEPTH(DEPTH), .AW(AW), .OVERWRITE(1)
    ) dut1 (.clk(clk), .reset_n(rst_n), .bus(ifc1));

    int checks = 0;
    int errors = 0;

    // Reference model: stored words as a queue, phase 0=capture 1=drain 2=done
    word_t mq0[$];
    word_t mq1[$];
    int    mph [2];
    bit    movf[2];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic word_t qfront(input int k);
        return (k == 0) ? mq0[0] : mq1[0];
    endfunction

    task automatic qpush(input int k, input word_t w);
        if (k == 0) mq0.push_back(w); else mq1.push_back(w);
    endtask

    task automatic qpop(input int k);
        if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
    endtask

    task automatic mstep();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                if (k == 0) mq0.delete(); else mq1.delete();
                mph[k]  = 0;
                movf[k] = 1'b0;
            end else if (mph[k] == 0) begin
                if (tv) begin
                    if (qsize(k) < int'(DEPTH)) begin
                        qpush(k, td);
                    end else begin
                        movf[k] = 1'b1;
                        if (k == 1) begin
                            qpop(k);
                            qpush(k, td);
                        end
                    end
                end
                if (te) mph[k] = 1;
            end else if (mph[k] == 1) begin
                if (qsize(k) == 0) mph[k] = 2;
                else if (dr) qpop(k);
            end
        end
    endtask

    task automatic mcheck();
        logic [31:0] cnt, vld, dat, ovf, endd;
        bit          ev;
        for (int k = 0; k < 2; k++) begin
            cnt  = (k == 0) ? 32'(ifc0.dct_count)      : 32'(ifc1.dct_count);
            vld  = (k == 0) ? 32'(ifc0.dump_valid)     : 32'(ifc1.dump_valid);
            dat  = (k == 0) ? 32'(ifc0.dump_data)      : 32'(ifc1.dump_data);
            ovf  = (k == 0) ? 32'(ifc0.overflow)       : 32'(ifc1.overflow);
            endd = (k == 0) ? 32'(ifc0.test_has_ended) : 32'(ifc1.test_has_ended);
            ev   = (mph[k] == 1) && (qsize(k) > 0);
            chk("model_count", k, cnt, 32'(qsize(k)));
            chk("model_valid", k, vld, 32'(ev));
            chk("model_overflow", k, ovf, 32'(movf[k]));
            chk("model_ended", k, endd, 32'(mph[k] == 2));
            if (ev) chk("model_data", k, dat, 32'(qfront(k)));
            else if (mph[k] == 0) chk("model_data_idle", k, dat, 32'd0);
        end
    endtask

    task automatic drive(input bit r, input bit v, input word_t d, input bit e, input bit rdy);
        rst_n = r; tv = v; td = d; te = e; dr = rdy;
    endtask

    task automatic cycle();
        @(posedge clk);
        mstep();
        #1;
        mcheck();
    endtask

    typedef struct {
        bit    rst_n, tv;
        word_t td;
        bit    te, dr;
        int    cnt;
        bit    vld;
        word_t data;
        bit    chkd, ovf, endd;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(bit r, bit v, int d, bit e, bit rdy,
                                int c, bit vl, int dt, bit cd, bit o, bit en);
        vec_t x;
        x.rst_n = r; x.tv = v; x.td = word_t'(d); x.te = e; x.dr = rdy;
        x.cnt = c; x.vld = vl; x.data = word_t'(dt); x.chkd = cd; x.ovf = o; x.endd = en;
        return x;
    endfunction

    word_t exp_q[$];
    word_t got0[$];
    word_t got1[$];

    initial begin
        //              rst tv td te dr | cnt vld data chkd ovf end
        vecs[0]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        vecs[1]  = mk(1, 1, 1, 0, 0,   1, 0, 0, 1, 0, 0);
        vecs[2]  = mk(1, 1, 2, 0, 0,   2, 0, 0, 1, 0, 0);
        vecs[3]  = mk(1, 1, 3, 0, 0,   3, 0, 0, 1, 0, 0);
        vecs[4]  = mk(1, 1, 4, 0, 0,   4, 0, 0, 1, 0, 0);
        vecs[5]  = mk(1, 1, 5, 1, 1,   5, 1, 1, 1, 0, 0);
        vecs[6]  = mk(1, 0, 0, 0, 1,   4, 1, 2, 1, 0, 0);
        vecs[7]  = mk(1, 0, 0, 0, 1,   3, 1, 3, 1, 0, 0);
        vecs[8]  = mk(1, 0, 0, 0, 1,   2, 1, 4, 1, 0, 0);
        vecs[9]  = mk(1, 0, 0, 0, 1,   1, 1, 5, 1, 0, 0);
        vecs[10] = mk(1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        vecs[11] = mk(1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1);
        vecs[12] = mk(1, 1, 9, 1, 1,   0, 0, 0, 0, 0, 1);
        vecs[13] = mk(0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        vecs[14] = mk(1, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0);
        vecs[15] = mk(1, 1, 7, 0, 0,   0, 0, 0, 0, 0, 1);
        vecs[16] = mk(1, 1, 8, 0, 0,   0, 0, 0, 0, 0, 1);

        drive(0, 0, '0, 0, 0);
        mph[0] = 0; mph[1] = 0; movf[0] = 0; movf[1] = 0;

        // Directed table: 5-word capture/drain, then empty-buffer drain
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst_n, vecs[i].tv, vecs[i].td, vecs[i].te, vecs[i].dr);
            cycle();
            chk("vec_count", 0, 32'(ifc0.dct_count), 32'(vecs[i].cnt));
            chk("vec_count", 1, 32'(ifc1.dct_count), 32'(vecs[i].cnt));
            chk("vec_valid", 0, 32'(ifc0.dump_valid), 32'(vecs[i].vld));
            chk("vec_valid", 1, 32'(ifc1.dump_valid), 32'(vecs[i].vld));
            chk("vec_ended", 0, 32'(ifc0.test_has_ended), 32'(vecs[i].endd));
            chk("vec_ovf", 0, 32'(ifc0.overflow), 32'(vecs[i].ovf));
            if (vecs[i].chkd) begin
                chk("vec_data", 0, 32'(ifc0.dump_data), 32'(vecs[i].data));
                chk("vec_data", 1, 32'(ifc1.dump_data), 32'(vecs[i].data));
            end
        end

        // Over-fill with 20 words: drop mode keeps 0..15, ring mode keeps 4..19
        drive(0, 0, '0, 0, 0); cycle();
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, word_t'(i), 0, 0); cycle();
        end
        chk("full_count", 0, 32'(ifc0.dct_count), 32'd16);
        chk("full_count", 1, 32'(ifc1.dct_count), 32'd16);
        chk("full_ovf", 0, 32'(ifc0.overflow), 32'd1);
        chk("full_ovf", 1, 32'(ifc1.overflow), 32'd1);
        got0.delete(); got1.delete();
        drive(1, 0, '0, 1, 1); cycle();
        for (int n = 0; n < 40 && !(ifc0.test_has_ended && ifc1.test_has_ended); n++) begin
            if (ifc0.dump_valid) got0.push_back(ifc0.dump_data);
            if (ifc1.dump_valid) got1.push_back(ifc1.dump_data);
            drive(1, 0, '0, 0, 1); cycle();
        end
        chk("ovf_drain_ended", 0, 32'(ifc0.test_has_ended), 32'd1);
        chk("ovf_drain_ended", 1, 32'(ifc1.test_has_ended), 32'd1);
        chk("drop_drain_len", 0, 32'(got0.size()), 32'd16);
        chk("ring_drain_len", 1, 32'(got1.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < got0.size()) chk("drop_drain_word", 0, 32'(got0[i]), 32'(i));
            if (i < got1.size()) chk("ring_drain_word", 1, 32'(got1[i]), 32'(i + 4));
        end

        // Backpressure: ready toggles every cycle, every word accepted once in order
        drive(0, 0, '0, 0, 0); cycle();
        exp_q.delete(); got0.delete(); got1.delete();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(word_t'($urandom));
            drive(1, 1, exp_q[i], 0, 0); cycle();
        end
        drive(1, 0, '0, 1, 0); cycle();
        for (int n = 0; n < 60 && !(ifc0.test_has_ended && ifc1.test_has_ended); n++) begin
            drive(1, 0, '0, 0, n[0]);
            if (ifc0.dump_valid && dr) got0.push_back(ifc0.dump_data);
            if (ifc1.dump_valid && dr) got1.push_back(ifc1.dump_data);
            cycle();
        end
        chk("bp_ended", 0, 32'(ifc0.test_has_ended), 32'd1);
        chk("bp_len", 0, 32'(got0.size()), 32'd6);
        chk("bp_len", 1, 32'(got1.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got0.size()) chk("bp_word", 0, 32'(got0[i]), 32'(exp_q[i]));
            if (i < got1.size()) chk("bp_word", 1, 32'(got1[i]), 32'(exp_q[i]));
        end

        // Reset held two cycles in the middle of a drain
        drive(0, 0, '0, 0, 0); cycle();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, word_t'(32'h100 + i), 0, 0); cycle();
        end
        drive(1, 0, '0, 1, 1); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, '0, 0, 1); cycle();
        end
        chk("mid_drain_count", 0, 32'(ifc0.dct_count), 32'd5);
        drive(0, 1, word_t'(32'h77), 1, 1); cycle(); cycle();
        chk("rst_count", 0, 32'(ifc0.dct_count), 32'd0);
        chk("rst_valid", 0, 32'(ifc0.dump_valid), 32'd0);
        chk("rst_ended", 0, 32'(ifc0.test_has_ended), 32'd0);
        drive(1, 1, word_t'(32'h55), 0, 1); cycle();
        chk("rst_capture", 0, 32'(ifc0.dct_count), 32'd1);
        chk("rst_capture", 1, 32'(ifc1.dct_count), 32'd1);
        chk("rst_capture_valid", 1, 32'(ifc1.dump_valid), 32'd0);

        // Random traffic against the model
        for (int r = 0; r < 6; r++) begin
            drive(0, 0, '0, 0, 0); cycle();
            for (int n = 0; n < 120; n++) begin
                drive($urandom_range(0, 149) != 0,
                      $urandom_range(0, 9) < (3 + r),
                      word_t'($urandom),
                      $urandom_range(0, 39) == 0,
                      $urandom_range(0, 2) != 0);
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
